// File: rtl/vedic_16bit_seq_mult_if.sv
// ----------------------------------------------------------------------------
// vedic_16bit_seq_mult_if
// Requester <-> multiplier handshake bundle.
//   start : request, accepted on an edge where ready=1
//   a, b  : 16-bit unsigned operands, sampled on the accepting edge
//   ready : multiplier idle and able to accept start
//   done  : one-cycle completion pulse; p valid from this cycle on
//   p     : 32-bit product, held until the next completion
// The master modport belongs to the requester, slave to the multiplier.
// ----------------------------------------------------------------------------
interface vedic_16bit_seq_mult_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic [31:0] p;

  modport master (output start, a, b, input  ready, done, p);
  modport slave  (input  start, a, b, output ready, done, p);
endinterface : vedic_16bit_seq_mult_if

// File: rtl/vedic_16bit_seq_mult.sv
// ----------------------------------------------------------------------------
// vedic_8bit_multi
// Combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from
// four 4x4 vertical-and-crosswise blocks.
//   a, b : 8-bit operands
//   p    : 16-bit product
// ----------------------------------------------------------------------------
module vedic_8bit_multi (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // 4x4 block: each column sum collects the crosswise bit products of
  // equal weight i+j.
  function automatic logic [7:0] ut4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r = r + (8'(x[i] & y[j]) << (i + j));
      end
    end
    return r;
  endfunction

  logic [7:0] q0, q1, q2, q3;

  assign q0 = ut4(a[3:0], b[3:0]);
  assign q1 = ut4(a[7:4], b[3:0]);
  assign q2 = ut4(a[3:0], b[7:4]);
  assign q3 = ut4(a[7:4], b[7:4]);

  assign p = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule : vedic_8bit_multi

// ----------------------------------------------------------------------------
// vedic_16bit_seq_mult
// 16x16 unsigned sequential multiplier. One shared 8x8 Vedic datapath is
// stepped over four partial products (cnt 0..3) and accumulated at 32 bits.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (aborts any operation in flight)
//   bus : slave side of vedic_16bit_seq_mult_if (start/a/b in,
//         ready/done/p out); all outputs are registered.
// Latency is 4 cycles from the accepting edge to done; a held start gives
// one product every 5 cycles.
// ----------------------------------------------------------------------------
module vedic_16bit_seq_mult (
  input logic                      clk,
  input logic                      rst,
  vedic_16bit_seq_mult_if.slave    bus
);
  typedef enum logic {IDLE, MUL} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [15:0] a_q,     a_d;
  logic [15:0] b_q,     b_d;
  logic [31:0] acc_q,   acc_d;
  logic [31:0] p_q,     p_d;
  logic        done_q,  done_d;
  logic        ready_q, ready_d;

  logic [7:0]  op_a, op_b;
  logic [15:0] pp;
  logic [31:0] term;

  // Operand mux: cnt[1] picks the high byte of a, cnt[0] the high byte of b,
  // giving the lo*lo, lo*hi, hi*lo, hi*hi schedule.
  assign op_a = cnt_q[1] ? a_q[15:8] : a_q[7:0];
  assign op_b = cnt_q[0] ? b_q[15:8] : b_q[7:0];

  vedic_8bit_multi u_mul8 (
    .p (pp),
    .a (op_a),
    .b (op_b)
  );

  // Partial product aligned at full 32-bit width so the shift-8 terms
  // carry cleanly into the upper byte.
  always_comb begin
    term = {16'b0, pp};
    case (cnt_q)
      2'd1, 2'd2: term = {8'b0, pp, 8'b0};
      2'd3:       term = {pp, 16'b0};
      default:    term = {16'b0, pp};
    endcase
  end

  // NOTE: every next-state signal takes its hold value before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + term;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          p_d     = acc_q + term;
          done_d  = 1'b1;
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // ready is registered from the next state so it never depends on start
    // combinationally.
    ready_d = (state_d == IDLE);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.p     = p_q;
endmodule : vedic_16bit_seq_mult
